// File: rtl/plic_target_claim.sv
// plic_target_claim: per-context threshold compare, claim/complete handshake and in-service tracking.
// Define PLIC_CLAIM_ERR_EN to add sticky error flag and saturating counter for ignored completes.
module plic_target_claim #(
  parameter int NUM_SOURCES       = 30,
  parameter int ID_BITWIDTH       = 5,
  parameter int PRIORITY_BITWIDTH = 3,
  parameter int HOLDOFF_CYCLES    = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [PRIORITY_BITWIDTH-1:0] max_priority_i,
  input  logic [ID_BITWIDTH-1:0]       max_id_i,
  input  logic [PRIORITY_BITWIDTH-1:0] threshold_i,
  output logic                         irq_o,
  input  logic                         claim_req_i,
  output logic                         claim_gnt_o,
  output logic                         claim_valid_o,
  output logic [ID_BITWIDTH-1:0]       claim_id_o,
  input  logic                         complete_req_i,
  input  logic [ID_BITWIDTH-1:0]       complete_id_i,
  output logic [NUM_SOURCES-1:0]       claim_o,
  output logic [NUM_SOURCES-1:0]       complete_o,
  output logic [NUM_SOURCES-1:0]       in_service_o
`ifdef PLIC_CLAIM_ERR_EN
  ,
  output logic                         complete_err_o,
  output logic [7:0]                   err_cnt_o
`endif
);
  localparam int CW = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;
  typedef enum logic {IDLE, HOLDOFF} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic eligible;
  logic [ID_BITWIDTH-1:0] cap_id;
  logic [NUM_SOURCES-1:0] claim_set, complete_hit;
  assign eligible = max_priority_i > threshold_i && max_id_i != '0 && 32'(max_id_i) <= NUM_SOURCES;
  assign claim_gnt_o = state == IDLE && claim_req_i;
  assign cap_id = eligible ? max_id_i : '0;
  // complete_hit looks at the pre-update mask so a same-cycle claim of that ID re-sets the bit
  always_comb begin
    claim_set = '0;
    complete_hit = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      claim_set[i] = claim_gnt_o && 32'(cap_id) == i + 1;
      complete_hit[i] = complete_req_i && 32'(complete_id_i) == i + 1 && in_service_o[i];
    end
  end
  always_comb begin
    state_d = state == IDLE ? (claim_gnt_o && cap_id != '0 ? HOLDOFF : IDLE) : (cnt == '0 ? IDLE : HOLDOFF);
    cnt_d = state == IDLE ? CW'(HOLDOFF_CYCLES - 1) : (cnt == '0 ? '0 : cnt - 1'b1);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt <= '0;
      irq_o <= 1'b0;
      claim_valid_o <= 1'b0;
      claim_id_o <= '0;
      claim_o <= '0;
      complete_o <= '0;
      in_service_o <= '0;
    end else begin
      state <= state_d;
      cnt <= state == IDLE && state_d == IDLE ? '0 : cnt_d;
      irq_o <= eligible && state == IDLE && !claim_gnt_o;
      claim_valid_o <= claim_gnt_o;
      if (claim_gnt_o) claim_id_o <= cap_id;
      claim_o <= claim_set;
      complete_o <= complete_hit;
      in_service_o <= (in_service_o & ~complete_hit) | claim_set;
    end
  end
`ifdef PLIC_CLAIM_ERR_EN
  logic ignored;
  assign ignored = complete_req_i && complete_hit == '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      complete_err_o <= 1'b0;
      err_cnt_o <= '0;
    end else if (ignored) begin
      complete_err_o <= 1'b1;
      err_cnt_o <= err_cnt_o + {7'd0, err_cnt_o != 8'hff};
    end
  end
`endif
endmodule

// File: tb/tb_plic_target_claim.sv
// tb_plic_target_claim: directed table, hand sequences and random run against a cycle-level reference model.
module tb_plic_target_claim;
  localparam int NS = 30;
  localparam int HOLD = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] max_priority = '0, threshold = '0;
  logic [4:0] max_id = '0, complete_id = '0, claim_id;
  logic claim_req = 1'b0, complete_req = 1'b0;
  logic irq, claim_gnt, claim_valid;
  logic [NS-1:0] claim_vec, complete_vec, in_service;
`ifdef PLIC_CLAIM_ERR_EN
  logic complete_err;
  logic [7:0] err_cnt;
`endif
  int tests = 0;
  int fails = 0;
  int busy;
  logic [NS-1:0] mask, m_claim, m_comp;
  bit m_irq, m_valid, m_err;
  int m_id, m_cnt;
  typedef struct {
    bit rq; int pr; int id; int th; bit cr; int ci;
    bit gnt; bit irq; bit vld; int cid; logic [NS-1:0] clm; logic [NS-1:0] cmp; logic [NS-1:0] ins;
  } vec_t;
  vec_t v[16];
  always #5 clk = ~clk;
  plic_target_claim dut (
    .clk_i(clk), .rst_ni(rst_n), .max_priority_i(max_priority), .max_id_i(max_id),
    .threshold_i(threshold), .irq_o(irq), .claim_req_i(claim_req), .claim_gnt_o(claim_gnt),
    .claim_valid_o(claim_valid), .claim_id_o(claim_id), .complete_req_i(complete_req),
    .complete_id_i(complete_id), .claim_o(claim_vec), .complete_o(complete_vec),
    .in_service_o(in_service)
`ifdef PLIC_CLAIM_ERR_EN
    , .complete_err_o(complete_err), .err_cnt_o(err_cnt)
`endif
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h, want %h", n, a, e);
    end
  endtask
  task automatic drive(input bit rq, input int pr, input int id, input int th, input bit cr, input int ci);
    claim_req = rq;
    max_priority = 3'(pr);
    max_id = 5'(id);
    threshold = 3'(th);
    complete_req = cr;
    complete_id = 5'(ci);
  endtask
  task automatic model_reset();
    busy = 0;
    mask = '0;
    m_id = 0;
    m_err = 0;
    m_cnt = 0;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask
  task automatic rand_cycle(input int n);
    bit rq, cr, idle, gnt, elig;
    int pr, th, id, ci, cap;
    rq = $urandom_range(0, 3) == 0;
    pr = $urandom_range(0, 7);
    th = $urandom_range(0, 7);
    id = $urandom_range(0, 9) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 6);
    cr = $urandom_range(0, 2) == 0;
    ci = $urandom_range(0, 9) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 6);
    drive(rq, pr, id, th, cr, ci);
    idle = busy == 0;
    gnt = idle && rq;
    elig = pr > th && id >= 1 && id <= NS;
    cap = elig ? id : 0;
    m_irq = elig && idle && !gnt;
    m_valid = gnt;
    if (gnt) m_id = cap;
    m_claim = (gnt && cap != 0) ? NS'(1) << (cap - 1) : '0;
    m_comp = (cr && ci >= 1 && ci <= NS && mask[ci-1]) ? NS'(1) << (ci - 1) : '0;
    if (cr && m_comp == '0) begin
      m_err = 1;
      if (m_cnt < 255) m_cnt++;
    end
    mask = (mask & ~m_comp) | m_claim;
    if (busy > 0) busy--;
    else if (gnt && cap != 0) busy = HOLD;
    #1 chk($sformatf("rnd%0d gnt", n), 32'(claim_gnt), 32'(gnt));
    @(posedge clk);
    #1;
    chk($sformatf("rnd%0d irq", n), 32'(irq), 32'(m_irq));
    chk($sformatf("rnd%0d valid", n), 32'(claim_valid), 32'(m_valid));
    chk($sformatf("rnd%0d claim_id", n), 32'(claim_id), 32'(m_id));
    chk($sformatf("rnd%0d claim_o", n), 32'(claim_vec), 32'(m_claim));
    chk($sformatf("rnd%0d complete_o", n), 32'(complete_vec), 32'(m_comp));
    chk($sformatf("rnd%0d in_service", n), 32'(in_service), 32'(mask));
`ifdef PLIC_CLAIM_ERR_EN
    chk($sformatf("rnd%0d err", n), 32'(complete_err), 32'(m_err));
    chk($sformatf("rnd%0d err_cnt", n), 32'(err_cnt), 32'(m_cnt));
`endif
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    v = '{
      '{1, 5, 7, 2, 0, 0,  1, 0, 1, 7, 30'h40, 30'h0,  30'h40},
      '{1, 5, 7, 5, 0, 0,  0, 0, 0, 7, 30'h0,  30'h0,  30'h40},
      '{1, 5, 7, 5, 0, 0,  0, 0, 0, 7, 30'h0,  30'h0,  30'h40},
      '{1, 5, 7, 5, 0, 0,  1, 0, 1, 0, 30'h0,  30'h0,  30'h40},
      '{0, 5, 7, 2, 1, 7,  0, 1, 0, 0, 30'h0,  30'h40, 30'h0},
      '{0, 5, 7, 2, 1, 7,  0, 1, 0, 0, 30'h0,  30'h0,  30'h0},
      '{0, 5, 7, 2, 1, 0,  0, 1, 0, 0, 30'h0,  30'h0,  30'h0},
      '{0, 5, 7, 2, 1, 31, 0, 1, 0, 0, 30'h0,  30'h0,  30'h0},
      '{1, 6, 3, 2, 0, 0,  1, 0, 1, 3, 30'h4,  30'h0,  30'h4},
      '{0, 6, 3, 2, 0, 0,  0, 0, 0, 3, 30'h0,  30'h0,  30'h4},
      '{0, 6, 3, 2, 0, 0,  0, 0, 0, 3, 30'h0,  30'h0,  30'h4},
      '{0, 6, 3, 2, 0, 0,  0, 1, 0, 3, 30'h0,  30'h0,  30'h4},
      '{1, 6, 3, 2, 1, 3,  1, 0, 1, 3, 30'h4,  30'h4,  30'h4},
      '{0, 6, 3, 2, 1, 3,  0, 0, 0, 3, 30'h0,  30'h4,  30'h0},
      '{1, 5, 7, 2, 0, 0,  0, 0, 0, 3, 30'h0,  30'h0,  30'h0},
      '{1, 5, 7, 2, 0, 0,  1, 0, 1, 7, 30'h40, 30'h0,  30'h40}
    };
    drive(0, 5, 7, 2, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset irq", 32'(irq), 0);
    chk("reset in_service", 32'(in_service), 0);
    chk("reset valid", 32'(claim_valid), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("release irq", 32'(irq), 1);
    for (int i = 0; i < 16; i++) begin
      drive(v[i].rq, v[i].pr, v[i].id, v[i].th, v[i].cr, v[i].ci);
      #1 chk($sformatf("row%0d gnt", i), 32'(claim_gnt), 32'(v[i].gnt));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d irq", i), 32'(irq), 32'(v[i].irq));
      chk($sformatf("row%0d valid", i), 32'(claim_valid), 32'(v[i].vld));
      chk($sformatf("row%0d claim_id", i), 32'(claim_id), 32'(v[i].cid));
      chk($sformatf("row%0d claim_o", i), 32'(claim_vec), 32'(v[i].clm));
      chk($sformatf("row%0d complete_o", i), 32'(complete_vec), 32'(v[i].cmp));
      chk($sformatf("row%0d in_service", i), 32'(in_service), 32'(v[i].ins));
`ifdef PLIC_CLAIM_ERR_EN
      if (i == 5) chk("repeat complete err_cnt", 32'(err_cnt), 1);
      if (i == 5) chk("repeat complete err", 32'(complete_err), 1);
      if (i == 7) chk("out of range err_cnt", 32'(err_cnt), 3);
`endif
    end
    claim_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst valid", 32'(claim_valid), 0);
    chk("midrst claim_id", 32'(claim_id), 0);
    chk("midrst claim_o", 32'(claim_vec), 0);
    chk("midrst in_service", 32'(in_service), 0);
    chk("midrst irq", 32'(irq), 0);
    chk("midrst gnt", 32'(claim_gnt), 0);
    @(posedge clk);
    #1;
    drive(1, 5, 7, 2, 0, 0);
    rst_n = 1'b1;
    #1 chk("postrst idle gnt", 32'(claim_gnt), 1);
    @(posedge clk);
    #1;
    chk("postrst claim_id", 32'(claim_id), 7);
    chk("postrst claim_o", 32'(claim_vec), 32'h40);
    do_reset();
    for (int n = 0; n < 3000; n++) rand_cycle(n);
`ifdef PLIC_CLAIM_ERR_EN
    do_reset();
    for (int n = 0; n < 300; n++) begin
      drive(0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #1;
    end
    chk("saturated err_cnt", 32'(err_cnt), 255);
    chk("saturated err", 32'(complete_err), 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
